// File: rtl/tone_period_decoder.sv
// Measures toneIn half-periods in inClk cycles and decodes them against the 8-entry divider table.
// Optional TONE_DECODER_EXPECT_EN adds expectCode/codeMismatch for comparing against the switch setting.
module tone_period_decoder #(
    parameter int unsigned  TOL       = 256,
    parameter int unsigned  STABLE_N  = 4,
    parameter int unsigned  TIMEOUT   = 100000,
    // Entry k lives in bits [32k +: 32]; code 0 is the lowest word.
    parameter logic [255:0] REF_TABLE = {32'd23902, 32'd25330, 32'd28410, 32'd31929,
                                         32'd35817, 32'd37937, 32'd42590, 32'd47802}
) (
    input  logic        inClk,
    input  logic        reset,
    input  logic        toneIn,
`ifdef TONE_DECODER_EXPECT_EN
    input  logic [2:0]  expectCode,
    output logic        codeMismatch,
`endif
    output logic [31:0] halfPeriod,
    output logic        periodValid,
    output logic [2:0]  noteCode,
    output logic        noteValid,
    output logic [1:0]  dbgState
);

    localparam int SW = $clog2(STABLE_N + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(STABLE_N);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_s1;
    logic            r_s2;
    logic            r_s3;
    logic [31:0]     r_cnt;
    logic [31:0]     r_half;
    logic            r_pv;
    logic [2:0]      r_code;
    logic            r_valid;
    logic [2:0]      r_cand;
    logic [SW-1:0]   r_streak;

    logic            w_edge;
    logic [31:0]     w_interval;
    logic [31:0]     w_ref;
    logic [31:0]     w_diff;
    logic            w_match;
    logic [2:0]      w_match_k;
    logic [SW-1:0]   w_next_streak;
    logic [2:0]      w_next_cand;
    logic            w_lock;

    assign w_edge     = r_s2 ^ r_s3;
    assign w_interval = r_cnt + 32'd1;

    // Scan high to low so the lowest matching code wins if TOL is ever widened.
    always_comb begin
        w_ref     = '0;
        w_diff    = '0;
        w_match   = 1'b0;
        w_match_k = '0;
        for (int k = 7; k >= 0; k--) begin
            w_ref  = REF_TABLE[32*k +: 32];
            w_diff = (w_interval >= w_ref) ? (w_interval - w_ref) : (w_ref - w_interval);
            if (w_diff <= 32'(TOL)) begin
                w_match   = 1'b1;
                w_match_k = 3'(k);
            end
        end
    end

    always_comb begin
        w_next_streak = '0;
        w_next_cand   = r_cand;
        if (w_match) begin
            if ((r_streak != '0) && (w_match_k == r_cand)) begin
                w_next_streak = (r_streak == STREAK_MAX) ? STREAK_MAX : r_streak + 1'b1;
            end else begin
                w_next_streak = {{(SW-1){1'b0}}, 1'b1};
                w_next_cand   = w_match_k;
            end
        end
    end

    assign w_lock = (w_next_streak == STREAK_MAX);

    always_ff @(posedge inClk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_s3     <= 1'b0;
            r_cnt    <= '0;
            r_half   <= '0;
            r_pv     <= 1'b0;
            r_code   <= '0;
            r_valid  <= 1'b0;
            r_cand   <= '0;
            r_streak <= '0;
        end else begin
            r_s1 <= toneIn;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
            r_pv <= 1'b0;
            if (w_edge) begin
                r_cnt <= '0;
                case (r_state)
                    IDLE: begin
                        r_state <= ARM;
                    end
                    default: begin
                        r_state  <= MEASURE;
                        r_half   <= w_interval;
                        r_pv     <= 1'b1;
                        r_streak <= w_next_streak;
                        r_cand   <= w_next_cand;
                        r_valid  <= w_lock;
                        if (w_lock) begin
                            r_code <= w_next_cand;
                        end
                    end
                endcase
            end else begin
                r_cnt <= r_cnt + 32'd1;
                // An edge in the same cycle takes the branch above, so it always beats the timeout.
                if (r_cnt == 32'(TIMEOUT - 1)) begin
                    r_state  <= IDLE;
                    r_valid  <= 1'b0;
                    r_streak <= '0;
                end
            end
        end
    end

`ifdef TONE_DECODER_EXPECT_EN
    logic r_mismatch;

    always_ff @(posedge inClk) begin
        if (reset) begin
            r_mismatch <= 1'b0;
        end else begin
            r_mismatch <= r_valid && (r_code != expectCode);
        end
    end

    assign codeMismatch = r_mismatch;
`endif

    assign halfPeriod  = r_half;
    assign periodValid = r_pv;
    assign noteCode    = r_code;
    assign noteValid   = r_valid;
    assign dbgState    = r_state;

endmodule

// File: tb/tb_tone_period_decoder.sv
// Directed bench for tone_period_decoder with a scaled-down divider table so runs stay short.
// Build with TONE_DECODER_EXPECT_EN defined to also exercise expectCode/codeMismatch.
module tb_tone_period_decoder;

    localparam int unsigned  TOL      = 2;
    localparam int unsigned  STABLE_N = 4;
    localparam int unsigned  TIMEOUT  = 1000;
    localparam logic [255:0] REF_TABLE = {32'd239, 32'd253, 32'd284, 32'd319,
                                          32'd358, 32'd379, 32'd426, 32'd478};
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARM     = 2'd1;
    localparam logic [1:0] ST_MEASURE = 2'd2;

    logic        inClk = 1'b0;
    logic        reset;
    logic        toneIn;
    logic [31:0] halfPeriod;
    logic        periodValid;
    logic [2:0]  noteCode;
    logic        noteValid;
    logic [1:0]  dbgState;
`ifdef TONE_DECODER_EXPECT_EN
    logic [2:0]  expectCode;
    logic        codeMismatch;
`endif

    tone_period_decoder #(
        .TOL       (TOL),
        .STABLE_N  (STABLE_N),
        .TIMEOUT   (TIMEOUT),
        .REF_TABLE (REF_TABLE)
    ) dut (
        .inClk       (inClk),
        .reset       (reset),
        .toneIn      (toneIn),
`ifdef TONE_DECODER_EXPECT_EN
        .expectCode  (expectCode),
        .codeMismatch(codeMismatch),
`endif
        .halfPeriod  (halfPeriod),
        .periodValid (periodValid),
        .noteCode    (noteCode),
        .noteValid   (noteValid),
        .dbgState    (dbgState)
    );

    always #5 inClk = ~inClk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Output monitor: periodValid pulses, lock glitches, codes seen during the 3->4 relock.
    int         pv_cnt     = 0;
    int         valid_cnt  = 0;
    int         pulse_err  = 0;
    int         glitch_err = 0;
    int         bad_code   = 0;
    logic       win34      = 1'b0;
    logic       prev_pv    = 1'b0;
    logic       prev_valid = 1'b0;
    logic [2:0] prev_code  = 3'd0;

    always @(negedge inClk) begin
        if (periodValid === 1'b1) pv_cnt++;
        if (noteValid === 1'b1) valid_cnt++;
        if (prev_pv && periodValid) pulse_err++;
        if (prev_valid && noteValid && (noteCode != prev_code)) glitch_err++;
        if (win34 && noteValid && (noteCode != 3'd3) && (noteCode != 3'd4)) bad_code++;
        prev_pv    = periodValid;
        prev_valid = noteValid;
        prev_code  = noteCode;
    end

    task automatic toggle_tone();
        @(negedge inClk);
        toneIn = ~toneIn;
    endtask

    // n toggles, each followed by a gap of p cycles before the next toggle.
    task automatic run_vec(input int unsigned p, input int unsigned n);
        for (int i = 0; i < int'(n); i++) begin
            toggle_tone();
            repeat (p - 1) @(negedge inClk);
        end
    endtask

    typedef struct {
        int unsigned period;
        int unsigned n;
        logic [31:0] exp_half;
        logic [2:0]  exp_code;
        logic        exp_valid;
        int          exp_pv;
    } vec_t;

    vec_t vecs[12];

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pv0;

        // First toggle of a vector closes the interval opened by the previous vector's gap.
        vecs[0]  = '{478, 1,   0, 3'd0, 1'b0, 0};
        vecs[1]  = '{478, 1, 478, 3'd0, 1'b0, 1};
        vecs[2]  = '{478, 3, 478, 3'd0, 1'b1, 3};
        vecs[3]  = '{241, 1, 478, 3'd0, 1'b1, 1};
        vecs[4]  = '{241, 4, 241, 3'd7, 1'b1, 4};
        vecs[5]  = '{242, 1, 241, 3'd7, 1'b1, 1};
        vecs[6]  = '{242, 1, 242, 3'd7, 1'b0, 1};
        vecs[7]  = '{358, 1, 242, 3'd7, 1'b0, 1};
        vecs[8]  = '{358, 4, 358, 3'd3, 1'b1, 4};
        vecs[9]  = '{319, 1, 358, 3'd3, 1'b1, 1};
        vecs[10] = '{319, 1, 319, 3'd3, 1'b0, 1};
        vecs[11] = '{319, 3, 319, 3'd4, 1'b1, 3};

        reset  = 1'b1;
        toneIn = 1'b0;
`ifdef TONE_DECODER_EXPECT_EN
        expectCode = 3'd2;
`endif
        repeat (5) @(negedge inClk);
        check("rst_half",  halfPeriod, 0);
        check("rst_pv",    32'(periodValid), 0);
        check("rst_code",  32'(noteCode), 0);
        check("rst_valid", 32'(noteValid), 0);
        check("rst_state", 32'(dbgState), 32'(ST_IDLE));
        reset = 1'b0;

        repeat (3000) @(negedge inClk);
        check("idle_pv_cnt",    pv_cnt, 0);
        check("idle_valid_cnt", valid_cnt, 0);
        check("idle_state",     32'(dbgState), 32'(ST_IDLE));

        for (int i = 0; i < 12; i++) begin
            win34 = (i >= 9);
            pv0 = pv_cnt;
            run_vec(vecs[i].period, vecs[i].n);
            check($sformatf("v%0d_half", i),  halfPeriod, vecs[i].exp_half);
            check($sformatf("v%0d_code", i),  32'(noteCode), 32'(vecs[i].exp_code));
            check($sformatf("v%0d_valid", i), 32'(noteValid), 32'(vecs[i].exp_valid));
            check($sformatf("v%0d_pv", i),    pv_cnt - pv0, vecs[i].exp_pv);
        end
        win34 = 1'b0;

        // Edge lands exactly TIMEOUT cycles after the previous one: measured, not timed out.
        pv0 = pv_cnt;
        repeat (TIMEOUT - 1 - 318) @(negedge inClk);
        toggle_tone();
        repeat (5) @(negedge inClk);
        check("edge_on_to_state", 32'(dbgState), 32'(ST_MEASURE));
        check("edge_on_to_half",  halfPeriod, TIMEOUT);
        check("edge_on_to_valid", 32'(noteValid), 0);
        check("edge_on_to_pv",    pv_cnt - pv0, 1);

        // Relock on code 4, then freeze the tone.
        repeat (319 - 1 - 5) @(negedge inClk);
        run_vec(319, 4);
        check("relock_valid", 32'(noteValid), 1);
        check("relock_code",  32'(noteCode), 4);
        repeat (TIMEOUT + 2 - 318) @(negedge inClk);
        check("pre_to_valid", 32'(noteValid), 1);
        check("pre_to_state", 32'(dbgState), 32'(ST_MEASURE));
        @(negedge inClk);
        check("to_valid", 32'(noteValid), 0);
        check("to_state", 32'(dbgState), 32'(ST_IDLE));
        check("to_half",  halfPeriod, 319);
        check("to_code",  32'(noteCode), 4);

        // First edge after a timeout only arms.
        pv0 = pv_cnt;
        toggle_tone();
        repeat (5) @(negedge inClk);
        check("post_to_state", 32'(dbgState), 32'(ST_ARM));
        check("post_to_pv",    pv_cnt - pv0, 0);

        // Reset in the middle of a measurement.
        run_vec(239, 2);
        check("pre_rst_state", 32'(dbgState), 32'(ST_MEASURE));
        reset = 1'b1;
        @(negedge inClk);
        check("mid_rst_half",  halfPeriod, 0);
        check("mid_rst_code",  32'(noteCode), 0);
        check("mid_rst_valid", 32'(noteValid), 0);
        check("mid_rst_state", 32'(dbgState), 32'(ST_IDLE));
        reset = 1'b0;
        pv0 = pv_cnt;
        run_vec(478, 1);
        check("after_rst_state", 32'(dbgState), 32'(ST_ARM));
        check("after_rst_half",  halfPeriod, 0);
        check("after_rst_pv",    pv_cnt - pv0, 0);

`ifdef TONE_DECODER_EXPECT_EN
        run_vec(379, 5);
        check("exp_lock_valid", 32'(noteValid), 1);
        check("exp_lock_code",  32'(noteCode), 2);
        check("exp_match",      32'(codeMismatch), 0);
        expectCode = 3'd5;
        @(negedge inClk);
        check("exp_mismatch",   32'(codeMismatch), 1);
        reset = 1'b1;
        @(negedge inClk);
        check("exp_rst",        32'(codeMismatch), 0);
        reset = 1'b0;
`endif

        check("pv_single_cycle",   pulse_err, 0);
        check("locked_code_glitch", glitch_err, 0);
        check("relock_3_4_codes",  bad_code, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
